// File: rtl/data_fetch_load.sv
// Load-path fetcher: reads a DIM x DIM tile from data BRAM and streams it row-major
// into the selected PEs' matrix registers, then pulses FETCH_DONE to the CU.
module data_fetch_load #(
  parameter int DATA_W = 8,
  parameter int MEM_AW = 8,
  parameter int N_PE   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ADDR_START,
  input  logic              ADDR_RST,
  input  logic [1:0]        DIMEN,
  input  logic [3:0]        ADDRESS,
  input  logic [1:0]        PE_SEL,
  input  logic              PE_SEL_2x2,
  input  logic              PE_SEL_4,
  output logic              MEM_EN,
  output logic [MEM_AW-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [N_PE-1:0]   PE_WR_EN,
  output logic [1:0]        PE_WR_ROW,
  output logic [1:0]        PE_WR_COL,
  output logic [DATA_W-1:0] PE_WR_DATA,
  output logic              BUSY,
  output logic              FETCH_DONE
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              r_state;
  logic                r_start_q;
  logic [1:0]          r_dim_m1;
  logic [MEM_AW-1:0]   r_base;
  logic [N_PE-1:0]     r_mask;
  logic [1:0]          r_row;
  logic [1:0]          r_col;
  logic                r_mem_en;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [N_PE-1:0]     r_wr_en;
  logic [1:0]          r_wr_row;
  logic [1:0]          r_wr_col;
  logic                r_busy;
  logic                r_done;

  logic                w_start;
  logic [MEM_AW-1:0]   w_base;
  logic [N_PE-1:0]     w_mask;
  logic [1:0]          w_nrow;
  logic [1:0]          w_ncol;
  logic                w_last;

  assign w_start = (r_state == IDLE) && ADDR_START && !r_start_q && !ADDR_RST;
  assign w_base  = MEM_AW'({ADDRESS, 4'b0000});
  assign w_last  = (r_row == r_dim_m1) && (r_col == r_dim_m1);

  always_comb begin
    if (PE_SEL_4)
      w_mask = '1;
    else if (PE_SEL_2x2)
      w_mask = PE_SEL[1] ? N_PE'(4'b1100) : N_PE'(4'b0011);
    else
      w_mask = N_PE'(1) << PE_SEL;
  end

  always_comb begin
    w_ncol = r_col + 2'd1;
    w_nrow = r_row;
    if (r_col == r_dim_m1) begin
      w_ncol = '0;
      w_nrow = r_row + 2'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_start_q  <= 1'b1;
      r_dim_m1   <= '0;
      r_base     <= '0;
      r_mask     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
      r_wr_en    <= '0;
      r_wr_row   <= '0;
      r_wr_col   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_start_q <= ADDR_START;
      // Write stage trails the read by one cycle, tagged with the read's row/col.
      r_wr_en   <= r_mem_en ? r_mask : '0;
      r_wr_row  <= r_row;
      r_wr_col  <= r_col;
      r_done    <= 1'b0;
      if (ADDR_RST) begin
        r_state    <= IDLE;
        r_row      <= '0;
        r_col      <= '0;
        r_mem_en   <= 1'b0;
        r_mem_addr <= '0;
        r_wr_en    <= '0;
        r_busy     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_start) begin
              r_dim_m1   <= DIMEN;
              r_base     <= w_base;
              r_mask     <= w_mask;
              r_row      <= '0;
              r_col      <= '0;
              r_mem_en   <= 1'b1;
              r_mem_addr <= w_base;
              r_busy     <= 1'b1;
              r_state    <= READ;
            end
          end
          READ: begin
            if (w_last) begin
              r_mem_en <= 1'b0;
              r_state  <= DRAIN;
            end else begin
              r_row      <= w_nrow;
              r_col      <= w_ncol;
              r_mem_addr <= r_base + MEM_AW'({w_nrow, w_ncol});
            end
          end
          DRAIN: begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
          DONE: begin
            r_busy  <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign MEM_EN     = r_mem_en;
  assign MEM_ADDR   = r_mem_addr;
  assign PE_WR_EN   = r_wr_en;
  assign PE_WR_ROW  = r_wr_row;
  assign PE_WR_COL  = r_wr_col;
  // Data is forced to zero outside write cycles so every output reads 0 in reset.
  assign PE_WR_DATA = (|r_wr_en) ? MEM_RDATA : '0;
  assign BUSY       = r_busy;
  assign FETCH_DONE = r_done;

endmodule

// File: tb/tb_data_fetch_load.sv
// Directed bench for data_fetch_load with a synchronous BRAM model.
module tb_data_fetch_load;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ADDR_START;
  logic       ADDR_RST;
  logic [1:0] DIMEN;
  logic [3:0] ADDRESS;
  logic [1:0] PE_SEL;
  logic       PE_SEL_2x2;
  logic       PE_SEL_4;
  logic       MEM_EN;
  logic [7:0] MEM_ADDR;
  logic [7:0] MEM_RDATA;
  logic [3:0] PE_WR_EN;
  logic [1:0] PE_WR_ROW;
  logic [1:0] PE_WR_COL;
  logic [7:0] PE_WR_DATA;
  logic       BUSY;
  logic       FETCH_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [256];

  always #5 CLK = ~CLK;

  data_fetch_load #(.DATA_W(8), .MEM_AW(8), .N_PE(4)) dut (
    .CLK(CLK), .RST(RST), .ADDR_START(ADDR_START), .ADDR_RST(ADDR_RST),
    .DIMEN(DIMEN), .ADDRESS(ADDRESS), .PE_SEL(PE_SEL), .PE_SEL_2x2(PE_SEL_2x2),
    .PE_SEL_4(PE_SEL_4), .MEM_EN(MEM_EN), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .PE_WR_EN(PE_WR_EN), .PE_WR_ROW(PE_WR_ROW), .PE_WR_COL(PE_WR_COL),
    .PE_WR_DATA(PE_WR_DATA), .BUSY(BUSY), .FETCH_DONE(FETCH_DONE)
  );

  always @(posedge CLK) if (MEM_EN) MEM_RDATA <= mem[MEM_ADDR];

  function automatic logic [7:0] mem_val(input logic [7:0] a);
    return a ^ 8'h3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] all_outs();
    return {5'b0, MEM_EN, MEM_ADDR, PE_WR_EN, PE_WR_ROW, PE_WR_COL, PE_WR_DATA, BUSY, FETCH_DONE};
  endfunction

  // Leaves the bench at cycle k+1 (just after the accepting edge).
  task automatic start_cmd(input logic [1:0] dimen, input logic [3:0] addr,
                           input logic [1:0] sel, input logic s22, input logic s4);
    ADDR_START = 1'b0;
    tick();
    DIMEN = dimen; ADDRESS = addr; PE_SEL = sel; PE_SEL_2x2 = s22; PE_SEL_4 = s4;
    ADDR_START = 1'b1;
    tick();
  endtask

  task automatic run_fetch(input string name, input logic [1:0] dimen, input logic [3:0] addr,
                           input logic [1:0] sel, input logic s22, input logic s4,
                           input logic [3:0] mask, input bit hold);
    int unsigned dim, n, idx;
    logic [7:0] base, a;
    dim  = 32'(dimen) + 1;
    n    = dim * dim;
    base = {addr, 4'b0000};
    start_cmd(dimen, addr, sel, s22, s4);
    // Scramble the command inputs: the running fetch must ignore them.
    DIMEN = ~dimen; ADDRESS = ~addr; PE_SEL = ~sel; PE_SEL_2x2 = ~s22; PE_SEL_4 = ~s4;
    if (!hold) ADDR_START = 1'b0;
    for (int unsigned j = 1; j <= n + 2; j++) begin
      chk({name, "_busy"}, 32'(BUSY), 32'd1);
      chk({name, "_done"}, 32'(FETCH_DONE), 32'(j == n + 2));
      chk({name, "_mem_en"}, 32'(MEM_EN), 32'(j <= n));
      if (j <= n) begin
        idx = j - 1;
        a = base + 8'(((idx / dim) * 4) + (idx % dim));
        chk({name, "_mem_addr"}, 32'(MEM_ADDR), 32'(a));
      end
      if (j >= 2 && j <= n + 1) begin
        idx = j - 2;
        a = base + 8'(((idx / dim) * 4) + (idx % dim));
        chk({name, "_wr_en"}, 32'(PE_WR_EN), 32'(mask));
        chk({name, "_wr_row"}, 32'(PE_WR_ROW), idx / dim);
        chk({name, "_wr_col"}, 32'(PE_WR_COL), idx % dim);
        chk({name, "_wr_data"}, 32'(PE_WR_DATA), 32'(mem_val(a)));
      end else begin
        chk({name, "_wr_idle"}, 32'(PE_WR_EN), 32'd0);
      end
      tick();
    end
    chk({name, "_end"}, {29'b0, BUSY, FETCH_DONE, MEM_EN}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = mem_val(8'(i));
    RST = 1'b1; ADDR_START = 1'b1; ADDR_RST = 1'b0;
    DIMEN = '0; ADDRESS = '0; PE_SEL = '0; PE_SEL_2x2 = 1'b0; PE_SEL_4 = 1'b0;
    #12;
    chk("reset_outs", all_outs(), 32'd0);
    #10 RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("start_held_thru_reset", {30'b0, MEM_EN, BUSY}, 32'd0);
    end

    run_fetch("t1", 2'd1, 4'h3, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b0);
    run_fetch("t2", 2'd3, 4'hF, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b0);
    run_fetch("t3", 2'd0, 4'h0, 2'b10, 1'b1, 1'b0, 4'b1100, 1'b0);
    run_fetch("t3b", 2'd0, 4'h5, 2'b01, 1'b1, 1'b0, 4'b0011, 1'b0);

    // Start held high: exactly one fetch.
    run_fetch("t4", 2'd1, 4'h7, 2'd3, 1'b0, 1'b0, 4'b1000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk("t4_no_refetch", {29'b0, MEM_EN, BUSY, FETCH_DONE}, 32'd0);
      tick();
    end
    ADDR_START = 1'b0;

    // Abort mid-fetch; start asserted together with the abort is ignored.
    start_cmd(2'd3, 4'h2, 2'd1, 1'b0, 1'b0);
    ADDR_START = 1'b0;
    tick(); tick();
    chk("t5_pre_wr", 32'(PE_WR_EN), 32'b0010);
    ADDR_RST = 1'b1; ADDR_START = 1'b1;
    tick();
    chk("t5_abort", {27'b0, MEM_EN, PE_WR_EN}, 32'd0);
    chk("t5_abort_busy", {30'b0, BUSY, FETCH_DONE}, 32'd0);
    ADDR_RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_quiet", {26'b0, MEM_EN, PE_WR_EN, FETCH_DONE}, 32'd0);
    end
    run_fetch("t5_restart", 2'd1, 4'h9, 2'd0, 1'b0, 1'b0, 4'b0001, 1'b0);

    // Asynchronous reset in READ, start held across release.
    start_cmd(2'd3, 4'hA, 2'd0, 1'b0, 1'b1);
    tick(); tick();
    #2 RST = 1'b1;
    #1 chk("t6_async_rst", all_outs(), 32'd0);
    tick();
    #3 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_start", {29'b0, MEM_EN, BUSY, FETCH_DONE}, 32'd0);
    end
    run_fetch("t6_after", 2'd0, 4'hC, 2'd3, 1'b0, 1'b0, 4'b1000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
